// File: rtl/datapath_param_if.sv
// SLC-3 datapath control/status bundle: controller-driven loads, gates, mux selects, memory data in;
// datapath-driven architectural state out. Zero latency (wires only).
// Backpressure: memory read data is qualified by mem_ready; mdr_busy reports an outstanding MDR load.
interface datapath_param_if #(
    parameter int DW    = 16,
    parameter int LED_W = 12
);
    // register load enables
    logic             LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
    // bus driver enables, one-hot or all zero
    logic             GatePC, GateMDR, GateALU, GateMARMUX;
    // 2:1 selects and MDR source select
    logic             SR2MUX, ADDR1MUX, MARMUX, DRMUX, SR1MUX, MIO_EN;
    // 4:1 selects and ALU operation
    logic [1:0]       PCMUX, ADDR2MUX, ALUK;
    // memory read data and its valid
    logic [DW-1:0]    MDR_in;
    logic             mem_ready;
    // registered architectural state
    logic [DW-1:0]    MAR, MDR, PC, IR;
    logic [LED_W-1:0] LED;
    logic             BEN, mdr_busy, bus_err;

    modport master (
        output LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
        output GatePC, GateMDR, GateALU, GateMARMUX,
        output SR2MUX, ADDR1MUX, MARMUX, DRMUX, SR1MUX, MIO_EN,
        output PCMUX, ADDR2MUX, ALUK, MDR_in, mem_ready,
        input  MAR, MDR, PC, IR, LED, BEN, mdr_busy, bus_err
    );

    modport slave (
        input  LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
        input  GatePC, GateMDR, GateALU, GateMARMUX,
        input  SR2MUX, ADDR1MUX, MARMUX, DRMUX, SR1MUX, MIO_EN,
        input  PCMUX, ADDR2MUX, ALUK, MDR_in, mem_ready,
        output MAR, MDR, PC, IR, LED, BEN, mdr_busy, bus_err
    );
endinterface

// File: rtl/datapath_param.sv
// SLC-3 datapath: PC/IR/MAR/MDR, 8xDW register file, CC, BEN, LED latch on one gated internal bus.
// Latency: all state updates at the next Clk edge; MDR memory loads take 1 edge, or k+1 edges when
// mem_ready is low for k cycles. Backpressure: mdr_busy is high while an MDR load waits on mem_ready.
// Ports: Clk, Reset (synchronous, active-low), dp (datapath_param_if.slave: controls in, state out).
module datapath_param #(
    parameter int DW    = 16,
    parameter int LED_W = 12
) (
    input  logic            Clk,
    input  logic            Reset,
    datapath_param_if.slave dp
);
    typedef enum logic {S_IDLE, S_WAIT} mdr_state_t;

    logic [DW-1:0]    pc_q, pc_d, ir_q, ir_d, mar_q, mar_d, mdr_q, mdr_d;
    logic [LED_W-1:0] led_q, led_d;
    logic [DW-1:0]    rf_q [8];
    logic             n_q, z_q, p_q, n_d, z_d, p_d;
    logic             ben_q, ben_d, err_q, err_d;
    mdr_state_t       state_q, state_d;

    logic [2:0]       sr1, sr2, dr;
    logic [DW-1:0]    sr1_val, sr2_val, alu_b, alu_out;
    logic [DW-1:0]    addr1, addr2, adder, marmux_out, bus;
    logic [3:0]       gates;
    logic             contention;
    logic             ir_unused;

    // ISA fields live in IR[15:0]; only the low 12 bits feed the datapath.
    assign ir_unused = ^ir_q[DW-1:12];

    assign sr1     = dp.SR1MUX ? ir_q[8:6] : ir_q[11:9];
    assign sr2     = ir_q[2:0];
    assign dr      = dp.DRMUX ? 3'b111 : ir_q[11:9];
    assign sr1_val = rf_q[sr1];
    assign sr2_val = rf_q[sr2];
    assign alu_b   = dp.SR2MUX ? {{(DW-5){ir_q[4]}}, ir_q[4:0]} : sr2_val;

    always_comb begin
        alu_out = '0;
        case (dp.ALUK)
            2'b00:   alu_out = sr1_val + alu_b;
            2'b01:   alu_out = sr1_val & alu_b;
            2'b10:   alu_out = ~sr1_val;
            default: alu_out = sr1_val;
        endcase
    end

    assign addr1 = dp.ADDR1MUX ? sr1_val : pc_q;

    always_comb begin
        addr2 = '0;
        case (dp.ADDR2MUX)
            2'b00:   addr2 = '0;
            2'b01:   addr2 = {{(DW-6){ir_q[5]}}, ir_q[5:0]};
            2'b10:   addr2 = {{(DW-9){ir_q[8]}}, ir_q[8:0]};
            default: addr2 = {{(DW-11){ir_q[10]}}, ir_q[10:0]};
        endcase
    end

    assign adder      = addr1 + addr2;
    assign marmux_out = dp.MARMUX ? adder : {{(DW-8){1'b0}}, ir_q[7:0]};

    // More than one gate set means at least two bits: x & (x-1) clears only the lowest one.
    assign gates      = {dp.GatePC, dp.GateMDR, dp.GateALU, dp.GateMARMUX};
    assign contention = (gates & (gates - 4'd1)) != 4'd0;

    // Contention and no-driver both fall to the default: bus reads as zero.
    always_comb begin
        bus = '0;
        case (gates)
            4'b1000: bus = pc_q;
            4'b0100: bus = mdr_q;
            4'b0010: bus = alu_out;
            4'b0001: bus = marmux_out;
            default: bus = '0;
        endcase
    end

    always_comb begin
        pc_d  = pc_q;
        ir_d  = dp.LD_IR  ? bus : ir_q;
        mar_d = dp.LD_MAR ? bus : mar_q;
        led_d = dp.LD_LED ? ir_q[LED_W-1:0] : led_q;
        n_d   = n_q;
        z_d   = z_q;
        p_d   = p_q;
        ben_d = ben_q;
        err_d = err_q | contention;
        if (dp.LD_PC) begin
            case (dp.PCMUX)
                2'b00:   pc_d = pc_q + DW'(1);
                2'b01:   pc_d = bus;
                2'b10:   pc_d = adder;
                default: pc_d = pc_q;
            endcase
        end
        if (dp.LD_CC) begin
            n_d = bus[DW-1];
            z_d = (bus == '0);
            p_d = !bus[DW-1] && (bus != '0);
        end
        // Uses the pre-edge CC, so a same-cycle LD_CC does not affect BEN.
        if (dp.LD_BEN) begin
            ben_d = (n_q & ir_q[11]) | (z_q & ir_q[10]) | (p_q & ir_q[9]);
        end
    end

    // MDR load sequencer; LD_MDR is ignored while a memory read is outstanding.
    always_comb begin
        state_d = state_q;
        mdr_d   = mdr_q;
        case (state_q)
            S_IDLE: begin
                if (dp.LD_MDR) begin
                    if (!dp.MIO_EN) begin
                        mdr_d = bus;
                    end else if (dp.mem_ready) begin
                        mdr_d = dp.MDR_in;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (dp.mem_ready) begin
                    mdr_d   = dp.MDR_in;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            pc_q    <= '0;
            ir_q    <= '0;
            mar_q   <= '0;
            mdr_q   <= '0;
            led_q   <= '0;
            n_q     <= 1'b0;
            z_q     <= 1'b1;
            p_q     <= 1'b0;
            ben_q   <= 1'b0;
            err_q   <= 1'b0;
            state_q <= S_IDLE;
            for (int i = 0; i < 8; i++) rf_q[i] <= '0;
        end else begin
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            mar_q   <= mar_d;
            mdr_q   <= mdr_d;
            led_q   <= led_d;
            n_q     <= n_d;
            z_q     <= z_d;
            p_q     <= p_d;
            ben_q   <= ben_d;
            err_q   <= err_d;
            state_q <= state_d;
            if (dp.LD_REG) rf_q[dr] <= bus;
        end
    end

    assign dp.PC       = pc_q;
    assign dp.IR       = ir_q;
    assign dp.MAR      = mar_q;
    assign dp.MDR      = mdr_q;
    assign dp.LED      = led_q;
    assign dp.BEN      = ben_q;
    assign dp.bus_err  = err_q;
    assign dp.mdr_busy = (state_q == S_WAIT);
endmodule

// File: tb/tb_datapath_param.sv
// Bench for datapath_param: a 16-bit and a 32-bit build driven by the same controls.
// Directed steps followed by random steps, each checked against a behavioural model.
module tb_datapath_param;
    logic Clk;
    logic Reset;
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
    logic gate_pc, gate_mdr, gate_alu, gate_marmux;
    logic sr2mux, addr1mux, marmux, drmux, sr1mux, mio_en, mem_ready;
    logic [1:0] pcmux, addr2mux, aluk;
    logic [31:0] mdr_in;

    wire [24:0] ctl = {ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led,
                       gate_pc, gate_mdr, gate_alu, gate_marmux,
                       sr2mux, addr1mux, marmux, drmux, sr1mux, mio_en,
                       pcmux, addr2mux, aluk, mem_ready};

    datapath_param_if #(.DW(16), .LED_W(12)) d16 ();
    datapath_param_if #(.DW(32), .LED_W(12)) d32 ();

    assign {d16.LD_MAR, d16.LD_MDR, d16.LD_IR, d16.LD_BEN, d16.LD_CC, d16.LD_REG, d16.LD_PC, d16.LD_LED,
            d16.GatePC, d16.GateMDR, d16.GateALU, d16.GateMARMUX,
            d16.SR2MUX, d16.ADDR1MUX, d16.MARMUX, d16.DRMUX, d16.SR1MUX, d16.MIO_EN,
            d16.PCMUX, d16.ADDR2MUX, d16.ALUK, d16.mem_ready} = ctl;
    assign {d32.LD_MAR, d32.LD_MDR, d32.LD_IR, d32.LD_BEN, d32.LD_CC, d32.LD_REG, d32.LD_PC, d32.LD_LED,
            d32.GatePC, d32.GateMDR, d32.GateALU, d32.GateMARMUX,
            d32.SR2MUX, d32.ADDR1MUX, d32.MARMUX, d32.DRMUX, d32.SR1MUX, d32.MIO_EN,
            d32.PCMUX, d32.ADDR2MUX, d32.ALUK, d32.mem_ready} = ctl;
    assign d16.MDR_in = mdr_in[15:0];
    assign d32.MDR_in = mdr_in;

    datapath_param #(.DW(16), .LED_W(12)) u_dut16 (.Clk(Clk), .Reset(Reset), .dp(d16));
    datapath_param #(.DW(32), .LED_W(12)) u_dut32 (.Clk(Clk), .Reset(Reset), .dp(d32));

    int checks = 0;
    int passes = 0;

    // Reference state, index 0 = 16-bit build, 1 = 32-bit build. CC held as sign: -1, 0, +1.
    logic [63:0] m_pc[2], m_ir[2], m_mar[2], m_mdr[2], m_led[2];
    logic [63:0] m_r[2][8];
    logic        m_ben[2], m_wait[2], m_err[2];
    int          m_cc[2];

    task automatic chk(input string tag, input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s/%s observed=%0h expected=%0h", tag, name, obs, exp);
    endtask

    function automatic logic [63:0] sx(input logic [63:0] v, input int bits, input logic [63:0] mask);
        logic [63:0] fld;
        fld = v & ((64'h1 << bits) - 64'h1);
        if (fld[bits-1]) fld = fld | ~((64'h1 << bits) - 64'h1);
        return fld & mask;
    endfunction

    task automatic clear_ctl();
        {ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led} = '0;
        {gate_pc, gate_mdr, gate_alu, gate_marmux} = '0;
        {sr2mux, addr1mux, marmux, drmux, sr1mux, mio_en, mem_ready} = '0;
        {pcmux, addr2mux, aluk} = '0;
        mdr_in = '0;
        Reset  = 1'b1;
    endtask

    task automatic check_all(input string tag);
        chk(tag, "pc16",   64'(d16.PC),       m_pc[0]);
        chk(tag, "ir16",   64'(d16.IR),       m_ir[0]);
        chk(tag, "mar16",  64'(d16.MAR),      m_mar[0]);
        chk(tag, "mdr16",  64'(d16.MDR),      m_mdr[0]);
        chk(tag, "led16",  64'(d16.LED),      m_led[0]);
        chk(tag, "ben16",  64'(d16.BEN),      64'(m_ben[0]));
        chk(tag, "busy16", 64'(d16.mdr_busy), 64'(m_wait[0]));
        chk(tag, "err16",  64'(d16.bus_err),  64'(m_err[0]));
        chk(tag, "pc32",   64'(d32.PC),       m_pc[1]);
        chk(tag, "ir32",   64'(d32.IR),       m_ir[1]);
        chk(tag, "mar32",  64'(d32.MAR),      m_mar[1]);
        chk(tag, "mdr32",  64'(d32.MDR),      m_mdr[1]);
        chk(tag, "led32",  64'(d32.LED),      m_led[1]);
        chk(tag, "ben32",  64'(d32.BEN),      64'(m_ben[1]));
        chk(tag, "busy32", 64'(d32.mdr_busy), 64'(m_wait[1]));
        chk(tag, "err32",  64'(d32.bus_err),  64'(m_err[1]));
    endtask

    // Predict the next state from the current controls, clock once, compare, then drop the controls.
    task automatic step(input string tag);
        logic [63:0] n_pc[2], n_ir[2], n_mar[2], n_mdr[2], n_led[2];
        logic [63:0] n_r[2][8];
        logic        n_ben[2], n_wait[2], n_err[2];
        int          n_cc[2];
        for (int i = 0; i < 2; i++) begin
            logic [63:0] mask, ir, a, b, alu, addr1, addr2, sum, mm, bus;
            int w, ng;
            w    = (i == 0) ? 16 : 32;
            mask = (64'h1 << w) - 64'h1;
            ir   = m_ir[i];
            a    = m_r[i][sr1mux ? ir[8:6] : ir[11:9]];
            b    = sr2mux ? sx(ir, 5, mask) : m_r[i][ir[2:0]];
            case (aluk)
                2'd0:    alu = (a + b) & mask;
                2'd1:    alu = a & b;
                2'd2:    alu = ~a & mask;
                default: alu = a;
            endcase
            addr1 = addr1mux ? a : m_pc[i];
            case (addr2mux)
                2'd0:    addr2 = 64'h0;
                2'd1:    addr2 = sx(ir, 6, mask);
                2'd2:    addr2 = sx(ir, 9, mask);
                default: addr2 = sx(ir, 11, mask);
            endcase
            sum = (addr1 + addr2) & mask;
            mm  = marmux ? sum : (ir & 64'hFF);
            ng  = $countones({gate_pc, gate_mdr, gate_alu, gate_marmux});
            bus = 64'h0;
            if (ng == 1) begin
                if (gate_pc)       bus = m_pc[i];
                else if (gate_mdr) bus = m_mdr[i];
                else if (gate_alu) bus = alu;
                else               bus = mm;
            end
            n_pc[i]  = m_pc[i];
            n_ir[i]  = ld_ir  ? bus : m_ir[i];
            n_mar[i] = ld_mar ? bus : m_mar[i];
            n_mdr[i] = m_mdr[i];
            n_led[i] = ld_led ? (ir & 64'hFFF) : m_led[i];
            n_ben[i] = m_ben[i];
            n_wait[i] = m_wait[i];
            n_err[i] = m_err[i] | (ng > 1);
            n_cc[i]  = m_cc[i];
            for (int j = 0; j < 8; j++) n_r[i][j] = m_r[i][j];
            if (ld_reg) n_r[i][drmux ? 3'd7 : ir[11:9]] = bus;
            if (ld_cc) n_cc[i] = bus[w-1] ? -1 : ((bus == 64'h0) ? 0 : 1);
            if (ld_ben) n_ben[i] = (m_cc[i] < 0 && ir[11]) || (m_cc[i] == 0 && ir[10]) || (m_cc[i] > 0 && ir[9]);
            if (ld_pc) begin
                case (pcmux)
                    2'd0:    n_pc[i] = (m_pc[i] + 64'h1) & mask;
                    2'd1:    n_pc[i] = bus;
                    2'd2:    n_pc[i] = sum;
                    default: n_pc[i] = m_pc[i];
                endcase
            end
            if (m_wait[i]) begin
                if (mem_ready) begin
                    n_mdr[i]  = 64'(mdr_in) & mask;
                    n_wait[i] = 1'b0;
                end
            end else if (ld_mdr) begin
                if (!mio_en)        n_mdr[i]  = bus;
                else if (mem_ready) n_mdr[i]  = 64'(mdr_in) & mask;
                else                n_wait[i] = 1'b1;
            end
            if (!Reset) begin
                n_pc[i] = 64'h0; n_ir[i] = 64'h0; n_mar[i] = 64'h0; n_mdr[i] = 64'h0; n_led[i] = 64'h0;
                n_ben[i] = 1'b0; n_wait[i] = 1'b0; n_err[i] = 1'b0; n_cc[i] = 0;
                for (int j = 0; j < 8; j++) n_r[i][j] = 64'h0;
            end
        end
        @(posedge Clk);
        @(negedge Clk);
        for (int i = 0; i < 2; i++) begin
            m_pc[i] = n_pc[i]; m_ir[i] = n_ir[i]; m_mar[i] = n_mar[i]; m_mdr[i] = n_mdr[i];
            m_led[i] = n_led[i]; m_ben[i] = n_ben[i]; m_wait[i] = n_wait[i]; m_err[i] = n_err[i];
            m_cc[i] = n_cc[i];
            for (int j = 0; j < 8; j++) m_r[i][j] = n_r[i][j];
        end
        check_all(tag);
        clear_ctl();
    endtask

    task automatic load_mdr(input logic [31:0] v);
        ld_mdr = 1'b1; mio_en = 1'b1; mem_ready = 1'b1; mdr_in = v;
        step("ldmdr");
    endtask

    task automatic load_ir(input logic [15:0] v);
        load_mdr(32'(v));
        gate_mdr = 1'b1; ld_ir = 1'b1;
        step("ldir");
    endtask

    task automatic load_reg(input logic [2:0] r, input logic [31:0] v);
        load_ir({4'h0, r, 9'h0});
        load_mdr(v);
        gate_mdr = 1'b1; ld_reg = 1'b1;
        step("ldreg");
    endtask

    task automatic all_ld();
        {ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led} = '1;
    endtask

    initial begin
        int g;
        for (int i = 0; i < 2; i++) begin
            m_pc[i] = 0; m_ir[i] = 0; m_mar[i] = 0; m_mdr[i] = 0; m_led[i] = 0;
            m_ben[i] = 0; m_wait[i] = 0; m_err[i] = 0; m_cc[i] = 0;
            for (int j = 0; j < 8; j++) m_r[i][j] = 0;
        end
        clear_ctl();

        // Reset held two cycles with every load requested.
        Reset = 1'b0; all_ld(); step("rst0");
        Reset = 1'b0; all_ld(); step("rst1");
        chk("rst", "pc16",   64'(d16.PC), 64'h0);
        chk("rst", "mdr32",  64'(d32.MDR), 64'h0);
        chk("rst", "ben16",  64'(d16.BEN), 64'h0);
        chk("rst", "busy16", 64'(d16.mdr_busy), 64'h0);
        chk("rst", "err16",  64'(d16.bus_err), 64'h0);
        load_ir(16'h0400); ld_ben = 1'b1; step("rst_ccz");
        chk("rst", "cc_is_z", 64'(d16.BEN), 64'h1);

        // ADD R1,R1,#1 from 5, then ADD R1,R1,#-1 from 1.
        load_reg(3'd1, 32'h5);
        load_ir(16'h1261);
        gate_alu = 1'b1; sr1mux = 1'b1; sr2mux = 1'b1; aluk = 2'd0; ld_reg = 1'b1; ld_cc = 1'b1;
        step("add1");
        ld_ben = 1'b1; step("add1_ben");
        chk("add1", "cc_is_p", 64'(d32.BEN), 64'h1);
        gate_alu = 1'b1; sr1mux = 1'b1; aluk = 2'd3; ld_mar = 1'b1; step("add1_rd");
        chk("add1", "r1", 64'(d16.MAR), 64'h6);
        load_reg(3'd1, 32'h1);
        load_ir(16'h127F);
        gate_alu = 1'b1; sr1mux = 1'b1; sr2mux = 1'b1; aluk = 2'd0; ld_reg = 1'b1; ld_cc = 1'b1;
        step("addm1");
        gate_alu = 1'b1; sr1mux = 1'b1; aluk = 2'd3; ld_mar = 1'b1; step("addm1_rd");
        chk("addm1", "r1", 64'(d32.MAR), 64'h0);
        load_ir(16'h0400); ld_ben = 1'b1; step("addm1_ben");
        chk("addm1", "cc_is_z", 64'(d16.BEN), 64'h1);

        // Memory wait: ready low three cycles, stray LD_MDR inside the wait.
        ld_mdr = 1'b1; mio_en = 1'b1; step("mw0");
        chk("mw0", "busy", 64'(d16.mdr_busy), 64'h1);
        step("mw1");
        ld_mdr = 1'b1; gate_pc = 1'b1; step("mw2");
        chk("mw2", "busy", 64'(d32.mdr_busy), 64'h1);
        mem_ready = 1'b1; mdr_in = 32'hBEEF; step("mw3");
        chk("mw3", "mdr", 64'(d16.MDR), 64'hBEEF);
        chk("mw3", "busy", 64'(d16.mdr_busy), 64'h0);

        // PC increment wrap, PC-relative branch target, PC-through-bus reload, hold.
        load_mdr(32'hFFFF); gate_mdr = 1'b1; ld_pc = 1'b1; pcmux = 2'd1; step("pcld");
        ld_pc = 1'b1; pcmux = 2'd0; step("pcinc");
        chk("pcinc", "pc16", 64'(d16.PC), 64'h0);
        chk("pcinc", "pc32", 64'(d32.PC), 64'h10000);
        load_mdr(32'h3000); gate_mdr = 1'b1; ld_pc = 1'b1; pcmux = 2'd1; step("pcld2");
        load_ir(16'h0FFE);
        ld_pc = 1'b1; addr2mux = 2'd2; pcmux = 2'd2; step("pcoff");
        chk("pcoff", "pc16", 64'(d16.PC), 64'h2FFE);
        chk("pcoff", "pc32", 64'(d32.PC), 64'h2FFE);
        gate_pc = 1'b1; ld_pc = 1'b1; pcmux = 2'd1; step("pcself");
        chk("pcself", "pc16", 64'(d16.PC), 64'h2FFE);
        ld_pc = 1'b1; pcmux = 2'd3; step("pchold");

        // Width: AND then NOT on an all-ones register.
        load_reg(3'd2, 32'hFFFFFFFF);
        load_ir(16'h5482);
        gate_alu = 1'b1; sr1mux = 1'b1; aluk = 2'd1; ld_reg = 1'b1; ld_cc = 1'b1; step("and");
        load_ir(16'h0800); ld_ben = 1'b1; step("and_ben");
        chk("and", "cc_is_n", 64'(d32.BEN), 64'h1);
        load_ir(16'h5482);
        gate_alu = 1'b1; sr1mux = 1'b1; aluk = 2'd2; ld_reg = 1'b1; ld_cc = 1'b1; ld_led = 1'b1; step("not");
        chk("not", "led32", 64'(d32.LED), 64'h482);
        gate_alu = 1'b1; sr1mux = 1'b1; aluk = 2'd3; ld_mar = 1'b1; step("not_rd");
        chk("not", "r2", 64'(d32.MAR), 64'h0);
        load_ir(16'h0400); ld_ben = 1'b1; step("not_ben");
        chk("not", "cc_is_z", 64'(d32.BEN), 64'h1);

        // Contention: bus forced to zero, sticky error until reset.
        gate_pc = 1'b1; gate_mdr = 1'b1; ld_mar = 1'b1; step("cont");
        chk("cont", "mar", 64'(d16.MAR), 64'h0);
        chk("cont", "err", 64'(d16.bus_err), 64'h1);
        step("cont_hold");
        chk("cont_hold", "err", 64'(d32.bus_err), 64'h1);
        Reset = 1'b0; step("cont_rst");
        chk("cont_rst", "err", 64'(d16.bus_err), 64'h0);

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            {ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led} = 8'($urandom) & 8'($urandom);
            {sr2mux, addr1mux, marmux, drmux, sr1mux, mio_en, mem_ready} = 7'($urandom);
            {pcmux, addr2mux, aluk} = 6'($urandom);
            mdr_in = $urandom;
            g = $urandom_range(0, 19);
            if (g < 16) begin
                case (g % 4)
                    0:       gate_pc = 1'b1;
                    1:       gate_mdr = 1'b1;
                    2:       gate_alu = 1'b1;
                    default: gate_marmux = 1'b1;
                endcase
            end else if (g == 16) begin
                gate_alu = 1'b1; gate_marmux = 1'b1;
            end
            Reset = ($urandom_range(0, 39) != 0);
            step("rnd");
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/datapath_param.md
# datapath_param

Parametrised successor to the SLC-3 datapath. It holds the architectural state of the SLC-3 core: PC, IR, MAR, MDR, an 8-entry register file, condition codes, BEN and the LED latch. All of it is moved over a single one-hot-gated internal bus under control of the existing control FSM. New in this generation:

- data width is parametrised;
- MDR loads from memory use a ready handshake with a wait state;
- simultaneous bus drivers are detected and reported through a sticky flag.

## Interface
Parameters:
- DW, 16, datapath width; must be ≥16. ISA fields are always taken from IR[15:0].
- LED_W, 12, LED latch width; must be ≤DW.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  one clock; reset is synchronous and active-low.
- LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED  in  1 each  register load enables.
- GatePC, GateMDR, GateALU, GateMARMUX  in  1 each  bus driver enables; one-hot or all zero.
- SR2MUX, ADDR1MUX, MARMUX, DRMUX, SR1MUX  in  1 each  2:1 mux selects.
- MIO_EN  in  1  1 = MDR sources memory; 0 = MDR sources the bus.
- PCMUX, ADDR2MUX, ALUK  in  2 each  4:1 selects and ALU operation.
- MDR_in  in  DW  memory read data.
- mem_ready  in  1  memory read data valid.
- MAR, MDR, PC, IR  out  DW  registered architectural state.
- LED  out  LED_W  registered LED latch.
- BEN  out  1  registered branch enable.
- mdr_busy  out  1  high while an MDR memory load is waiting.
- bus_err  out  1  sticky bus contention flag.

## Operation
- **Sign extension:** sext(x) sign-extends field x to DW bits; zext(x) zero-extends it.
- **Bus:** exactly one Gate high drives the corresponding source. No Gate high gives bus = 0. Two or more Gates high force bus = 0 and set bus_err. bus_err is cleared only by reset.
- **Register file:** 8 × DW, written at the clock edge, with two asynchronous read ports.
  - SR1 address = SR1MUX ? IR[8:6] : IR[11:9].
  - SR2 address = IR[2:0].
  - DR address = DRMUX ? 3'b111 : IR[11:9].
  - LD_REG writes bus into R[DR].
- **ALU:** A = R[SR1]; B = SR2MUX ? sext(IR[4:0]) : R[SR2].
  - ALUK 00 = A+B (mod 2^DW), 01 = A&B, 10 = ~A, 11 = A.
- **Address adder:** ADDR1 = ADDR1MUX ? R[SR1] : PC.
  - ADDR2: 00 = 0, 01 = sext(IR[5:0]), 10 = sext(IR[8:0]), 11 = sext(IR[10:0]).
  - Sum is mod 2^DW.
- **MARMUX output:** MARMUX ? adder sum : zext(IR[7:0]).
- **PC:** on LD_PC, PCMUX 00 = PC+1 (wraps to 0), 01 = bus, 10 = adder sum, 11 = hold.
- **MAR, IR:** on their load enable, load from the bus.
- **LED:** on LD_LED, load IR[LED_W-1:0].
- **CC:** on LD_CC, N/Z/P are set from the bus value interpreted as signed DW. Exactly one CC bit is set.
- **BEN:** on LD_BEN, BEN <= (N&IR[11]) | (Z&IR[10]) | (P&IR[9]), evaluated with the current CC.
- **MDR state machine:** states IDLE and WAIT.
  - IDLE, LD_MDR & !MIO_EN: MDR <= bus.
  - IDLE, LD_MDR & MIO_EN & mem_ready: MDR <= MDR_in; stay in IDLE.
  - IDLE, LD_MDR & MIO_EN & !mem_ready: go to WAIT.
  - WAIT: mdr_busy = 1. LD_MDR is ignored. On the first cycle with mem_ready = 1, MDR <= MDR_in and go to IDLE.
  - Other loads keep working during WAIT; stalling the FSM is the controller's job.
- **Reset (Reset = 0 at an edge):** PC, IR, MAR, MDR, LED, all registers and BEN go to 0. CC = Z only. bus_err = 0, mdr_busy = 0, state = IDLE. Reset overrides every load, including in WAIT.

## Timing
- All state updates happen at the rising Clk edge. Bus, ALU and adder are combinational within the cycle.
- Register read during a same-cycle write returns the old value. The new value is visible the cycle after.
- MDR memory load latency:
  - 1 edge if mem_ready is high at request.
  - Otherwise k+1 edges, where k is the number of cycles mem_ready stays low.
  - mdr_busy rises the edge after the request and falls at the capture edge.
- bus_err rises at the edge that samples contention. It is registered and has no combinational path to the output.
- Simultaneous LD_PC (PCMUX=01) with GatePC reloads the old PC.
- Simultaneous LD_CC and LD_BEN: BEN uses the pre-edge CC.

## Test plan
- **Reset:** hold Reset=0 for 2 cycles with all LDs high → all outputs 0, CC=Z, BEN=0, mdr_busy=0, bus_err=0.
- **ADD immediate:** R1=0x0005, IR=0x1261 (ADD R1,R1,#1), GateALU, LD_REG, LD_CC → R1=0x0006, CC=P. Repeat with IR=0x127F (ADD R1,R1,#-1) from R1=0x0001 → R1=0, CC=Z.
- **Memory wait:** LD_MDR, MIO_EN=1, mem_ready low 3 cycles then high with MDR_in=0xBEEF → mdr_busy high 3 cycles, MDR=0xBEEF on the 4th edge. A second LD_MDR pulse during WAIT has no effect.
- **PC paths:**
  - PC=0xFFFF, PCMUX=00 → PC=0x0000.
  - PC=0x3000, IR=0x0FFE, ADDR1MUX=0, ADDR2MUX=10, PCMUX=10 → PC=0x2FFE.
- **Bus contention:** GatePC and GateMDR high together with LD_MAR → MAR=0 and bus_err=1. bus_err stays 1 after the Gates drop until Reset=0.
- **Width:** DW=32 build, R2=0xFFFFFFFF, IR=0x5482 (AND R2,R2,R2) then ALUK=10 → R2 = 0x00000000. CC=N after the AND, Z after the NOT. LED (LED_W=12) = IR[11:0].
